// File: rtl/multi_ch_bcd_conv.sv
// multi_ch_bcd_conv
//   Sequential binary-to-BCD converter (double-dabble, one bit per clock)
//   for CH_NUM channels converted in lockstep. With SIGNED_EN=1 each channel
//   is taken as two's complement and reported as sign + BCD magnitude.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold last result
//   CONV  | shifting BIN_W bits through the add-3/shift datapath
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   start     conversion request, sampled only in IDLE
//   bin_in    packed inputs, channel k at [k*BIN_W +: BIN_W]
//   busy      conversion in progress
//   done      one-cycle pulse, bcd_out/sign_out updated this cycle
//   sign_out  per-channel sign (1 = negative)
//   bcd_out   packed BCD, channel k at [k*BCD_DIGITS*4 +: BCD_DIGITS*4]
module multi_ch_bcd_conv #(
  parameter int CH_NUM     = 3,
  parameter int BIN_W      = 8,
  parameter int BCD_DIGITS = 3,
  parameter int SIGNED_EN  = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [CH_NUM*BIN_W-1:0]        bin_in,
  output logic                           busy,
  output logic                           done,
  output logic [CH_NUM-1:0]              sign_out,
  output logic [CH_NUM*BCD_DIGITS*4-1:0] bcd_out
);

  localparam int BCD_W = BCD_DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  localparam logic IDLE = 1'b0;
  localparam logic CONV = 1'b1;

  localparam longint DEC_RANGE = longint'(10) ** BCD_DIGITS;
  localparam longint BIN_MAX   = (longint'(1) << BIN_W) - 1;

  if (DEC_RANGE <= BIN_MAX) begin : g_bad_digits
    $error("multi_ch_bcd_conv: BCD_DIGITS too small for BIN_W");
  end

  logic                              state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [CH_NUM-1:0][BIN_W-1:0]      mag_q, mag_d;
  logic [CH_NUM-1:0][BCD_W-1:0]      bcd_q, bcd_d;
  logic [CH_NUM-1:0]                 sign_q, sign_d;
  logic [CH_NUM-1:0][BCD_W-1:0]      bcd_out_q, bcd_out_d;
  logic [CH_NUM-1:0]                 sign_out_q, sign_out_d;
  logic                              done_q, done_d;

  logic [CH_NUM-1:0][BCD_W-1:0]      bcd_adj;
  logic [CH_NUM-1:0][BCD_W-1:0]      bcd_sh;
  logic [CH_NUM-1:0][BIN_W-1:0]      mag_sh;

  // One double-dabble step for every channel: add 3 to digits >= 5, then
  // shift the magnitude MSB into the BCD LSB.
  always_comb begin
    bcd_adj = bcd_q;
    bcd_sh  = '0;
    mag_sh  = '0;
    for (int ch = 0; ch < CH_NUM; ch++) begin
      for (int d = 0; d < BCD_DIGITS; d++) begin
        if (bcd_adj[ch][d*4 +: 4] >= 4'd5)
          bcd_adj[ch][d*4 +: 4] = bcd_adj[ch][d*4 +: 4] + 4'd3;
      end
      bcd_sh[ch] = (bcd_adj[ch] << 1) | BCD_W'(mag_q[ch][BIN_W-1]);
      mag_sh[ch] = mag_q[ch] << 1;
    end
  end

  always_comb begin
    logic [BIN_W-1:0] cap;
    logic             neg;
    cap        = '0;
    neg        = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    sign_d     = sign_q;
    bcd_out_d  = bcd_out_q;
    sign_out_d = sign_out_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int ch = 0; ch < CH_NUM; ch++) begin
            cap = bin_in[ch*BIN_W +: BIN_W];
            neg = (SIGNED_EN != 0) && cap[BIN_W-1];
            sign_d[ch] = neg;
            // -2**(BIN_W-1) negates to itself, which is the correct
            // unsigned magnitude.
            mag_d[ch]  = neg ? (~cap + BIN_W'(1)) : cap;
          end
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      default: begin
        mag_d = mag_sh;
        bcd_d = bcd_sh;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          bcd_out_d  = bcd_sh;
          sign_out_d = sign_q;
          done_d     = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      bcd_q      <= '0;
      sign_q     <= '0;
      bcd_out_q  <= '0;
      sign_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      sign_q     <= sign_d;
      bcd_out_q  <= bcd_out_d;
      sign_out_q <= sign_out_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == CONV);
  assign done     = done_q;
  assign sign_out = sign_out_q;
  assign bcd_out  = bcd_out_q;

endmodule
